boot_rom_ctrl: RTL
==================

Name: boot_rom_ctrl

Overview:
Parametrised boot ROM controller that serves instruction fetches from a reset-loaded boot image until the processor reaches a programmable handoff address. At that point it raises a sticky change_source so the fetch mux switches to main instruction memory. Successor to the fixed 16-word boot ROM. Adds:
- configurable depth and handoff point
- a valid handshake on fetches
- a runtime patch port
- out-of-range error detection
- a boot watchdog

Parameters:
DATA_WIDTH, 32, instruction word width
ADDR_WIDTH, 32, fetch address width (word-indexed)
DEPTH, 16, boot image words; image words at index >= 16 load as 0 (NOP)
HANDOFF_ADDR, 15, word address whose fetch completes boot
TIMEOUT, 1024, max cycles in BOOT before failure; 0 disables watchdog

Ports:
clock  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
fetch_req  in  1  fetch request, one-cycle pulse or held
fetch_addr  in  ADDR_WIDTH  word address of requested instruction
inst_out  out  DATA_WIDTH  fetched instruction
inst_valid  out  1  inst_out valid this cycle
prog_we  in  1  patch write enable
prog_addr  in  clog2(DEPTH)  patch word address
prog_data  in  DATA_WIDTH  patch data
change_source  out  1  sticky: boot complete, fetch from main memory
boot_fail  out  1  sticky: watchdog expired
addr_err  out  1  sticky: fetch address >= DEPTH seen

Behaviour:
- Reset is synchronous, active-high on clock; the interface uses exactly rst and clock.
- Reset effects:
  - state <= BOOT, watchdog counter <= 0.
  - All outputs go to 0: inst_out, inst_valid, change_source, boot_fail, addr_err.
  - mem[i] <= BOOT_IMAGE[i] for all i < DEPTH, which discards any patches.
- States: BOOT, DONE, FAIL. FSM and counter are held while rst is high.
- BOOT, fetch_req=1:
  - Next cycle: inst_valid=1 and inst_out=mem[fetch_addr].
  - If fetch_addr >= DEPTH: inst_out=0 (NOP) and addr_err <= 1.
  - Latency is exactly 1 cycle; back-to-back requests give one response per cycle.
- BOOT, fetch_req=0: inst_valid <= 0 and inst_out holds its last value.
- Handoff:
  - An accepted fetch with fetch_addr==HANDOFF_ADDR moves the FSM to DONE.
  - change_source rises in the same cycle as that fetch's inst_valid, so the handoff instruction itself is still delivered.
- DONE:
  - Fetches are ignored; inst_valid stays 0.
  - change_source stays 1 until reset.
  - prog_we is ignored.
- Watchdog:
  - The counter increments each cycle in BOOT.
  - When TIMEOUT != 0 and the counter reaches TIMEOUT-1, the next state is FAIL and boot_fail <= 1.
- FAIL: fetches are ignored, inst_valid=0, sticky until reset. change_source stays 0.
- Simultaneous handoff fetch and watchdog expiry: handoff wins (DONE, boot_fail stays 0).
- Patch port: prog_we in BOOT writes mem[prog_addr] <= prog_data.
- Same-cycle fetch and patch to the same address: read-before-write, so the fetch returns the old word and the next fetch returns the new one.
- fetch_addr is compared across its full ADDR_WIDTH, so upper bits matter for the range check.
- Reset mid-boot or after DONE/FAIL:
  - Returns to BOOT with the image reloaded.
  - Flags cleared.
  - Any response due in that cycle is dropped (inst_valid=0).

Decomposition:
- Package boot_rom_pkg holds:
  - state enum {BOOT, DONE, FAIL}
  - NOP constant (all zeros)
  - BOOT_IMAGE constant array of 16 words, with unused indices returning 0
- One sub-module, boot_watchdog: counter, TIMEOUT compare, enable=state==BOOT, expire pulse output.
- FSM, memory and patch logic stay in boot_rom_ctrl.

Test Plan:
1. Reset, fetch_req=1, fetch_addr=1 -> next cycle inst_valid=1, inst_out=32'h38000002. change_source=0.
2. Sequential fetch of addresses 0..15 -> word 14 = 32'h80000000. On the cycle word 15 (=0) is valid, change_source=1. A further fetch of addr 3 gives inst_valid=0.
3. prog_we addr 5, data 32'hDEADBEEF, with a same-cycle fetch of addr 5 -> the fetch returns 32'h0C220000 (old word), the next fetch returns 32'hDEADBEEF. Reset, then fetch addr 5 -> 32'h0C220000 again.
4. Fetch addr 40 with DEPTH=16 -> inst_out=0, inst_valid=1, addr_err=1 and sticky. The FSM stays in BOOT.
5. TIMEOUT=8, no handoff -> boot_fail=1 at cycle 8 after reset release. Subsequent fetches give inst_valid=0. Handoff fetch issued on the expiry cycle -> change_source=1, boot_fail=0.
6. Reset asserted the cycle after a fetch request -> inst_valid=0, all flags 0, state BOOT, image intact.

Source files
------------

// File: rtl/boot_rom_pkg.sv
// -----------------------------------------------------------------------------
// boot_rom_pkg
// Shared types and constants for the boot ROM controller:
//   boot_state_e     - controller state (BOOT, DONE, FAIL)
//   NOP              - all-zero instruction returned for unused/out-of-range words
//   BOOT_IMAGE       - 16-word reset image
//   boot_image_word  - image lookup that returns NOP past the end of BOOT_IMAGE,
//                      so deeper ROM instances load zeros in the extra words
// -----------------------------------------------------------------------------
package boot_rom_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    DONE = 2'd1,
    FAIL = 2'd2
  } boot_state_e;

  localparam int IMAGE_WORDS = 16;

  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam logic [31:0] BOOT_IMAGE [IMAGE_WORDS] = '{
    32'h3C00_0000,  // 0
    32'h3800_0002,  // 1
    32'h7C09_03A6,  // 2
    32'h6000_0000,  // 3
    32'h3C20_0001,  // 4
    32'h0C22_0000,  // 5
    32'h3821_0100,  // 6
    32'h7C3E_0B78,  // 7
    32'h9001_0000,  // 8
    32'h8001_0004,  // 9
    32'h7C08_02A6,  // 10
    32'h4E80_0020,  // 11
    32'h6000_0000,  // 12
    32'h4800_0004,  // 13
    32'h8000_0000,  // 14
    32'h0000_0000   // 15
  };

  function automatic logic [31:0] boot_image_word(input int unsigned idx);
    if (idx < IMAGE_WORDS) begin
      return BOOT_IMAGE[idx[$clog2(IMAGE_WORDS)-1:0]];
    end
    return NOP;
  endfunction

endpackage

// File: rtl/boot_watchdog.sv
// -----------------------------------------------------------------------------
// boot_watchdog
// Counts cycles spent in BOOT and flags when the boot budget is exhausted.
// Ports:
//   clock   in   system clock
//   rst     in   synchronous active-high reset, clears the counter
//   enable  in   high while the controller is in BOOT; counter holds otherwise
//   expire  out  combinational pulse in the cycle whose edge makes it the
//                TIMEOUT-th BOOT cycle; never asserts when TIMEOUT == 0
// -----------------------------------------------------------------------------
module boot_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clock,
  input  logic rst,
  input  logic enable,
  output logic expire
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  always_comb begin
    count_d = enable ? count_q + 32'd1 : count_q;
  end

  // The counter has already seen TIMEOUT-1 BOOT edges; the coming edge is the
  // one that exhausts the budget.
  always_comb begin
    expire = (TIMEOUT != 0) && enable && (count_q == 32'(TIMEOUT - 1));
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/boot_rom_ctrl.sv
// -----------------------------------------------------------------------------
// boot_rom_ctrl
// Serves instruction fetches from a reset-loaded, patchable boot image until
// the fetch of HANDOFF_ADDR completes, then raises sticky change_source so the
// fetch mux moves to main memory. A watchdog fails the boot if handoff does not
// happen within TIMEOUT cycles.
// Ports:
//   clock, rst       system clock / synchronous active-high reset
//   fetch_req        fetch request (pulse or held), accepted only in BOOT
//   fetch_addr       word address; full width is range-checked against DEPTH
//   inst_out         fetched word, 1-cycle latency, holds when no response
//   inst_valid       inst_out carries a response this cycle
//   prog_we/addr/data  patch write into the image, honoured only in BOOT
//   change_source    sticky: handoff fetch delivered
//   boot_fail        sticky: watchdog expired before handoff
//   addr_err         sticky: a fetch at or beyond DEPTH was accepted
// -----------------------------------------------------------------------------
module boot_rom_ctrl
  import boot_rom_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int DEPTH        = 16,
  parameter int HANDOFF_ADDR = 15,
  parameter int TIMEOUT      = 1024
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic                     fetch_req,
  input  logic [ADDR_WIDTH-1:0]    fetch_addr,
  output logic [DATA_WIDTH-1:0]    inst_out,
  output logic                     inst_valid,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0]    prog_data,
  output logic                     change_source,
  output logic                     boot_fail,
  output logic                     addr_err
);

  localparam int IDX_W = $clog2(DEPTH);

  boot_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  logic [DATA_WIDTH-1:0] inst_out_q, inst_out_d;
  logic                  inst_valid_q, inst_valid_d;
  logic                  change_source_q, change_source_d;
  logic                  boot_fail_q, boot_fail_d;
  logic                  addr_err_q, addr_err_d;

  logic in_boot;
  logic accept;
  logic in_range;
  logic handoff;
  logic wd_expire;

  assign in_boot  = (state_q == BOOT);
  assign accept   = in_boot && fetch_req;
  assign in_range = (fetch_addr < ADDR_WIDTH'(DEPTH));
  assign handoff  = accept && (fetch_addr == ADDR_WIDTH'(HANDOFF_ADDR));

  boot_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock  (clock),
    .rst    (rst),
    .enable (in_boot),
    .expire (wd_expire)
  );

  // Next state: handoff takes priority over a watchdog expiry on the same edge.
  always_comb begin
    // NOTE: every comb-assigned signal gets a default first so no path leaves
    // it unassigned and a latch cannot be inferred.
    state_d = state_q;
    unique case (state_q)
      BOOT: begin
        if (handoff) begin
          state_d = DONE;
        end else if (wd_expire) begin
          state_d = FAIL;
        end
      end
      DONE:    state_d = DONE;
      FAIL:    state_d = FAIL;
      default: state_d = BOOT;
    endcase
  end

  // Registered outputs.
  always_comb begin
    inst_valid_d    = accept;
    inst_out_d      = inst_out_q;
    change_source_d = change_source_q || handoff;
    boot_fail_d     = boot_fail_q || (in_boot && wd_expire && !handoff);
    addr_err_d      = addr_err_q || (accept && !in_range);
    if (accept) begin
      inst_out_d = in_range ? mem_q[fetch_addr[IDX_W-1:0]] : '0;
    end
  end

  // Patch port. The fetch above reads mem_q, so a same-cycle fetch of the
  // patched word still returns the old contents.
  always_comb begin
    mem_d = mem_q;
    if (in_boot && prog_we && (32'(prog_addr) < 32'(DEPTH))) begin
      mem_d[prog_addr] = prog_data;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q         <= BOOT;
      inst_out_q      <= '0;
      inst_valid_q    <= 1'b0;
      change_source_q <= 1'b0;
      boot_fail_q     <= 1'b0;
      addr_err_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      inst_out_q      <= inst_out_d;
      inst_valid_q    <= inst_valid_d;
      change_source_q <= change_source_d;
      boot_fail_q     <= boot_fail_d;
      addr_err_q      <= addr_err_d;
    end
  end

  // NOTE: this storage is deliberately reset: reset reloads the boot image and
  // discards patches, so it is built from resettable flops rather than a RAM.
  always_ff @(posedge clock) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DATA_WIDTH'(boot_image_word(i));
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign inst_out      = inst_out_q;
  assign inst_valid    = inst_valid_q;
  assign change_source = change_source_q;
  assign boot_fail     = boot_fail_q;
  assign addr_err      = addr_err_q;

endmodule
